// File: rtl/simon_pkg.sv
// Shared definitions for the Simon button front end and game controller:
// button widths, input-FSM state encoding and the one-hot to index encoder.
package simon_pkg;

  localparam int BTN_W   = 2;
  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_REL = 2'd2
  } simon_in_state_t;

  // The highest set bit wins; callers only pass single-bit vectors.
  function automatic logic [BTN_W-1:0] onehot_to_idx(input logic [NUM_BTN-1:0] oh);
    logic [BTN_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (oh[i]) idx = BTN_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_button_input_if.sv
// Button-side bundle between the player buttons and the Simon controller.
// master drives raw buttons and the turn flag; slave is the input conditioner.
interface simon_button_input_if;
  import simon_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic               simonTurn;
  logic [BTN_W-1:0]   playerNum;
  logic               playerPressed;
  logic               chordError;
  logic [NUM_BTN-1:0] btnHeld;

  modport master (
    output btn_raw, simonTurn,
    input  playerNum, playerPressed, chordError, btnHeld
  );

  modport slave (
    input  btn_raw, simonTurn,
    output playerNum, playerPressed, chordError, btnHeld
  );

endinterface

// File: rtl/simon_debounce_bit.sv
// One button: 2-flop synchroniser followed by a counter debouncer that
// drives the clean level.
module simon_debounce_bit #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d;
  logic [3:0] cnt_q, cnt_d;

  // The level flips on the edge after the counter has reached TICKS, so a clean
  // press sampled at edge 0 shows up on the level at edge 2+DEBOUNCE_TICKS.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == TICKS) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = deb_q;

endmodule

// File: rtl/simon_button_input.sv
// Simon player-button conditioner: debounce, rising-edge detect, chord reject,
// single-cycle press strobe. Optional lockout feature: SIMON_INPUT_LOCKOUT_EN.
module simon_button_input
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input logic                 clk,
  input logic                 reset,
  simon_button_input_if.slave btn_if
);

  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_prev_q;
  logic [NUM_BTN-1:0] rise;
  logic               rise_single, rise_multi, all_released, lockout;

  simon_in_state_t    state_q;
  logic [BTN_W-1:0]   num_q;
  logic               pressed_q, chord_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    simon_debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_if.btn_raw[i]),
      .level_o(deb[i])
    );
  end

`ifdef SIMON_INPUT_LOCKOUT_EN
  assign lockout = btn_if.simonTurn;
`else
  logic unused_simon_turn;
  assign unused_simon_turn = btn_if.simonTurn;
  assign lockout           = 1'b0;
`endif

  assign rise         = deb & ~deb_prev_q;
  assign rise_single  = (rise != '0) && ((rise & (rise - NUM_BTN'(1))) == '0);
  assign rise_multi   = (rise != '0) && !rise_single;
  assign all_released = (deb == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      deb_prev_q <= '0;
      num_q      <= '0;
      pressed_q  <= 1'b0;
      chord_q    <= 1'b0;
    end else begin
      deb_prev_q <= deb;
      pressed_q  <= 1'b0;
      chord_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!lockout && rise_single) begin
            num_q     <= onehot_to_idx(rise);
            pressed_q <= 1'b1;
            state_q   <= HELD;
          end else if (!lockout && rise_multi) begin
            chord_q <= 1'b1;
            state_q <= WAIT_REL;
          end
        end
        HELD, WAIT_REL: begin
          if (all_released) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A button held during the controller's turn must be released before it counts.
      if (lockout && !all_released) state_q <= WAIT_REL;
    end
  end

  assign btn_if.playerNum     = num_q;
  assign btn_if.playerPressed = pressed_q;
  assign btn_if.chordError    = chord_q;
  assign btn_if.btnHeld       = deb;

endmodule

// File: tb/tb_simon_button_input.sv
// Directed bench for simon_button_input with DEBOUNCE_TICKS = 3.
// The lockout scenario is compiled in only with SIMON_INPUT_LOCKOUT_EN.
module tb_simon_button_input;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  simon_button_input_if bif();

  simon_button_input #(.DEBOUNCE_TICKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .btn_if(bif)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    bif.btn_raw   = 4'b1111;
    bif.simonTurn = 1'b0;
    reset         = 1'b1;
    #2;
    total++; if (bif.playerPressed !== 1'b0) begin bad++; $display("FAIL rst_pressed got=%b want=0", bif.playerPressed); end
    total++; if (bif.playerNum !== 2'd0) begin bad++; $display("FAIL rst_num got=%0d want=0", bif.playerNum); end
    total++; if (bif.chordError !== 1'b0) begin bad++; $display("FAIL rst_chord got=%b want=0", bif.chordError); end
    tick(3);
    total++; if (bif.btnHeld !== 4'b0000) begin bad++; $display("FAIL rst_held got=%b want=0000", bif.btnHeld); end
    bif.btn_raw = 4'b0000;
    reset       = 1'b0;
    tick(10);
    total++; if (bif.playerPressed !== 1'b0 || bif.btnHeld !== 4'b0000) begin
      bad++; $display("FAIL post_rst_idle pressed=%b held=%b want 0/0000", bif.playerPressed, bif.btnHeld);
    end
  endtask

  task automatic test_single_press;
    bif.btn_raw = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (bif.playerPressed !== (k == 6)) begin bad++; $display("FAIL single_strobe k=%0d got=%b want=%b", k, bif.playerPressed, (k == 6)); end
      total++; if (bif.btnHeld !== ((k >= 5) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL single_held k=%0d got=%b want=%b", k, bif.btnHeld, ((k >= 5) ? 4'b0100 : 4'b0000));
      end
      if (k == 6) begin
        total++; if (bif.playerNum !== 2'd2) begin bad++; $display("FAIL single_num got=%0d want=2", bif.playerNum); end
      end
    end
    bif.btn_raw = 4'b0000;
    tick(10);
    total++; if (bif.btnHeld !== 4'b0000) begin bad++; $display("FAIL single_release got=%b want=0000", bif.btnHeld); end
  endtask

  task automatic test_back_to_back;
    int strobes = 0;
    bif.btn_raw = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bif.playerPressed === 1'b1) strobes++;
      total++; if (bif.playerPressed !== (k == 6)) begin bad++; $display("FAIL repress_strobe k=%0d got=%b want=%b", k, bif.playerPressed, (k == 6)); end
    end
    total++; if (strobes != 1) begin bad++; $display("FAIL repress_count got=%0d want=1", strobes); end
    bif.btn_raw = 4'b0000;
    tick(10);
  endtask

  task automatic test_glitch;
    bif.btn_raw = 4'b0001;
    tick(2);
    bif.btn_raw = 4'b0000;
    for (int k = 2; k < 12; k++) begin
      tick();
      total++; if (bif.playerPressed !== 1'b0 || bif.btnHeld !== 4'b0000) begin
        bad++; $display("FAIL glitch k=%0d pressed=%b held=%b want 0/0000", k, bif.playerPressed, bif.btnHeld);
      end
    end
  endtask

  task automatic test_chord;
    bif.btn_raw = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (bif.chordError !== (k == 6)) begin bad++; $display("FAIL chord_err k=%0d got=%b want=%b", k, bif.chordError, (k == 6)); end
      total++; if (bif.playerPressed !== 1'b0) begin bad++; $display("FAIL chord_nostrobe k=%0d got=%b want=0", k, bif.playerPressed); end
    end
    bif.btn_raw = 4'b0000;
    tick(10);
    bif.btn_raw = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (bif.playerPressed !== (k == 6)) begin bad++; $display("FAIL chord_repress k=%0d got=%b want=%b", k, bif.playerPressed, (k == 6)); end
      total++; if (bif.chordError !== 1'b0) begin bad++; $display("FAIL chord_clean k=%0d got=%b want=0", k, bif.chordError); end
      if (k == 6) begin
        total++; if (bif.playerNum !== 2'd1) begin bad++; $display("FAIL chord_num got=%0d want=1", bif.playerNum); end
      end
    end
    bif.btn_raw = 4'b0000;
    tick(10);
  endtask

  task automatic test_hold_second;
    int strobes = 0;
    int chords  = 0;
    bif.btn_raw = 4'b1000;
    for (int c = 0; c < 200; c++) begin
      if (c == 50) bif.btn_raw = 4'b1010;
      tick();
      if (bif.playerPressed === 1'b1) begin
        strobes++;
        total++; if (bif.playerNum !== 2'd3) begin bad++; $display("FAIL hold_num c=%0d got=%0d want=3", c, bif.playerNum); end
      end
      if (bif.chordError === 1'b1) chords++;
    end
    total++; if (strobes != 1) begin bad++; $display("FAIL hold_strobes got=%0d want=1", strobes); end
    total++; if (chords != 0) begin bad++; $display("FAIL hold_chords got=%0d want=0", chords); end
    total++; if (bif.btnHeld !== 4'b1010) begin bad++; $display("FAIL hold_held got=%b want=1010", bif.btnHeld); end
    bif.btn_raw = 4'b0000;
    tick(10);
  endtask

  task automatic test_reset_mid_press;
    bif.btn_raw = 4'b0100;
    tick(4);
    reset = 1'b1;
    #1;
    total++; if (bif.playerNum !== 2'd0) begin bad++; $display("FAIL midrst_num got=%0d want=0", bif.playerNum); end
    total++; if (bif.playerPressed !== 1'b0 || bif.chordError !== 1'b0) begin
      bad++; $display("FAIL midrst_strobes pressed=%b chord=%b want 0/0", bif.playerPressed, bif.chordError);
    end
    tick(2);
    total++; if (bif.btnHeld !== 4'b0000) begin bad++; $display("FAIL midrst_held got=%b want=0000", bif.btnHeld); end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (bif.playerPressed !== (k == 6)) begin bad++; $display("FAIL midrst_strobe k=%0d got=%b want=%b", k, bif.playerPressed, (k == 6)); end
      if (k == 6) begin
        total++; if (bif.playerNum !== 2'd2) begin bad++; $display("FAIL midrst_pnum got=%0d want=2", bif.playerNum); end
      end
    end
    bif.btn_raw = 4'b0000;
    tick(10);
  endtask

`ifdef SIMON_INPUT_LOCKOUT_EN
  task automatic test_lockout;
    int strobes = 0;
    bif.simonTurn = 1'b1;
    bif.btn_raw   = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bif.playerPressed === 1'b1 || bif.chordError === 1'b1) strobes++;
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL lock_turn got=%0d want=0", strobes); end
    bif.simonTurn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bif.playerPressed === 1'b1) strobes++;
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL lock_drop got=%0d want=0", strobes); end
    bif.btn_raw = 4'b0000;
    tick(10);
    bif.btn_raw = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (bif.playerPressed !== (k == 6)) begin bad++; $display("FAIL lock_repress k=%0d got=%b want=%b", k, bif.playerPressed, (k == 6)); end
    end
    total++; if (bif.playerNum !== 2'd0) begin bad++; $display("FAIL lock_num got=%0d want=0", bif.playerNum); end
    bif.btn_raw = 4'b0000;
    tick(10);
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back();
    test_glitch();
    test_chord();
    test_hold_second();
    test_reset_mid_press();
`ifdef SIMON_INPUT_LOCKOUT_EN
    test_lockout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
